// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the write-back / register-file write-port slice:
// arbiter state encoding, write-source tags and default widths.
package wb_port_arbiter_pkg;

    localparam int WB_DATA_W = 8;
    localparam int WB_ADDR_W = 3;

    localparam logic RF_SRC_PIPE = 1'b0;
    localparam logic RF_SRC_HOST = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_PIPE = 2'd1,
        ARB_HOST = 2'd2
    } arb_state_t;

endpackage

// File: rtl/wb_pend_fifo.sv
// Small synchronous FIFO holding pipeline writes that are waiting for the
// register-file port. Head entry is visible combinationally for same-edge pop.
module wb_pend_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    // Storage needs no reset: only entries covered by count are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head_data = mem[rd_ptr_reg];
    assign full      = (count_reg == CNT_W'(DEPTH));
    assign empty     = (count_reg == '0);
    assign count     = count_reg;

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between the pipeline write-back
// stream (queued) and a host loader, with a starvation bound for the host.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DATA_W     = WB_DATA_W,
    parameter int ADDR_W     = WB_ADDR_W,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pipe_we,
    input  logic [ADDR_W-1:0] pipe_addr,
    input  logic [DATA_W-1:0] pipe_data,
    output logic              pipe_stall,
    input  logic              host_req,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_data,
    output logic              host_ack,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              rf_src,
    output logic              ovf
);

    localparam int CNT_W    = $clog2(DEPTH) + 1;
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    localparam int ENT_W    = ADDR_W + DATA_W;

    logic              fifo_push;
    logic              fifo_pop;
    logic [ENT_W-1:0]  fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    arb_state_t        state_reg, state_next;
    logic [STARVE_W-1:0] starve_reg, starve_next;
    logic              host_wait;
    logic [ADDR_W-1:0] rf_waddr_reg, rf_waddr_next;
    logic [DATA_W-1:0] rf_wdata_reg, rf_wdata_next;
    logic              rf_we_reg;
    logic              rf_src_reg;
    logic              host_ack_reg;
    logic              ovf_reg;

    wb_pend_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_pend_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({pipe_addr, pipe_data}),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign fifo_push              = pipe_we && !fifo_full;
    assign pipe_stall             = (fifo_count == CNT_W'(DEPTH));
    assign {head_addr, head_data} = fifo_head;

    // A request already acknowledged this cycle must not win again.
    always_comb begin
        state_next    = ARB_IDLE;
        starve_next   = starve_reg;
        fifo_pop      = 1'b0;
        rf_waddr_next = rf_waddr_reg;
        rf_wdata_next = rf_wdata_reg;
        host_wait     = host_req && (state_reg != ARB_HOST);

        if (host_wait && (fifo_empty || starve_reg == STARVE_W'(STARVE_MAX))) begin
            state_next    = ARB_HOST;
            starve_next   = '0;
            rf_waddr_next = host_addr;
            rf_wdata_next = host_data;
        end else if (!fifo_empty) begin
            state_next    = ARB_PIPE;
            fifo_pop      = 1'b1;
            rf_waddr_next = head_addr;
            rf_wdata_next = head_data;
            if (!host_wait) begin
                starve_next = '0;
            end else if (starve_reg != STARVE_W'(STARVE_MAX)) begin
                starve_next = starve_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ARB_IDLE;
            starve_reg   <= '0;
            rf_we_reg    <= 1'b0;
            rf_src_reg   <= RF_SRC_PIPE;
            host_ack_reg <= 1'b0;
            rf_waddr_reg <= '0;
            rf_wdata_reg <= '0;
            ovf_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            starve_reg   <= starve_next;
            rf_we_reg    <= (state_next != ARB_IDLE);
            rf_src_reg   <= (state_next == ARB_HOST) ? RF_SRC_HOST : RF_SRC_PIPE;
            host_ack_reg <= (state_next == ARB_HOST);
            rf_waddr_reg <= rf_waddr_next;
            rf_wdata_reg <= rf_wdata_next;
            ovf_reg      <= ovf_reg | (pipe_we & pipe_stall);
        end
    end

    assign rf_we    = rf_we_reg;
    assign rf_src   = rf_src_reg;
    assign host_ack = host_ack_reg;
    assign rf_waddr = rf_waddr_reg;
    assign rf_wdata = rf_wdata_reg;
    assign ovf      = ovf_reg;

endmodule
